// File: rtl/vlog_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : vlog_serial_tx
// Purpose  : Serial line transmitter. Accepts a parallel word on a valid/ready
//            handshake and sends one frame: a start bit, then WIDTH data bits
//            LSB first, then an optional even-parity bit, then a stop bit.
//            Each bit lasts DIV clock cycles.
// Options  : Define PARITY_EN to insert the even-parity bit before the stop bit.
// Revision : 1.0 - initial release
// ============================================================================
module vlog_serial_tx #(
   parameter int WIDTH = 8,
   parameter int DIV   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data_in,
   input  logic             valid,
   output logic             ready,
   output logic             tx,
   output logic             busy,
   output logic             done
);

   localparam int C_DCW = $clog2(DIV) + 1;
   localparam int C_BCW = $clog2(WIDTH + 1);
   localparam logic [C_DCW-1:0] C_DIV_LAST = C_DCW'(DIV - 1);
   localparam logic [C_BCW-1:0] C_BIT_LAST = C_BCW'(WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [C_DCW-1:0]   r_div_cnt;
   logic [C_BCW-1:0]   r_bit_cnt;
   logic [WIDTH-1:0]   r_shreg;
   logic               r_done;
   logic               w_tx;
   logic               w_accept;
   logic               w_bit_end;
   logic               w_last_bit;
`ifdef PARITY_EN
   logic               r_par;
`endif

   assign w_accept   = valid && (r_state == S_IDLE);
   assign w_bit_end  = (r_div_cnt == C_DIV_LAST);
   assign w_last_bit = (r_bit_cnt == C_BIT_LAST);

   assign ready = (r_state == S_IDLE);
   assign busy  = (r_state != S_IDLE);
   assign tx    = w_tx;
   assign done  = r_done;

   // State register; an asynchronous reset aborts any frame in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and line level for the current state.
   always_comb begin
      w_state_nxt = r_state;
      w_tx        = 1'b1;
      case (r_state)
         S_IDLE: begin
            if (valid) w_state_nxt = S_START;
         end
         S_START: begin
            w_tx = 1'b0;
            if (w_bit_end) w_state_nxt = S_DATA;
         end
         S_DATA: begin
            w_tx = r_shreg[0];
            if (w_bit_end && w_last_bit) begin
`ifdef PARITY_EN
               w_state_nxt = S_PARITY;
`else
               w_state_nxt = S_STOP;
`endif
            end
         end
`ifdef PARITY_EN
         S_PARITY: begin
            w_tx = r_par;
            if (w_bit_end) w_state_nxt = S_STOP;
         end
`endif
         S_STOP: begin
            if (w_bit_end) w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Word capture, bit timing, data shifting and the completion pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div_cnt <= '0;
         r_bit_cnt <= '0;
         r_shreg   <= '0;
         r_done    <= 1'b0;
`ifdef PARITY_EN
         r_par     <= 1'b0;
`endif
      end else begin
         r_done <= (r_state == S_STOP) && w_bit_end;
         if (w_accept) begin
            r_shreg   <= data_in;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
`ifdef PARITY_EN
            r_par     <= ^data_in;
`endif
         end else if (r_state != S_IDLE) begin
            if (w_bit_end) begin
               r_div_cnt <= '0;
               if (r_state == S_DATA) begin
                  r_shreg   <= r_shreg >> 1;
                  r_bit_cnt <= r_bit_cnt + 1'b1;
               end
            end else begin
               r_div_cnt <= r_div_cnt + 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire
